// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_MEM_LAT = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; the arbiter is the slave.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata,
      input  mem_en, mem_rw, mem_addr, mem_wdata, busy
   );

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata,
      output mem_en, mem_rw, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the fetch and data requesters.
// Build option: MEM_ARB_RR_EN selects round-robin on contention; otherwise dm
// always wins a tie.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    if_req,
   input  logic    dm_req,
   input  req_id_e last_id,
   output req_id_e winner
);

`ifndef MEM_ARB_RR_EN
   logic w_unused_last;
   assign w_unused_last = (last_id == REQ_DM);
`endif

   // Lone requester wins; a tie goes to dm or to whoever was not served last.
   always_comb begin
      winner = REQ_DM;
      if (if_req && !dm_req) begin
         winner = REQ_IF;
      end
`ifdef MEM_ARB_RR_EN
      else if (if_req && dm_req && (last_id == REQ_DM)) begin
         winner = REQ_IF;
      end
`endif
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port memory with fixed latency.
// Build option: MEM_ARB_RR_EN (round-robin contention; default is dm priority).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_port_arbiter_if.slave  bus
);

   localparam int unsigned    CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   req_id_e           r_id;
   logic              r_busy;
   logic              r_mem_en;
   logic              r_mem_rw;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_ack;
   logic              r_dm_ack;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;

   logic              w_any_req;
   req_id_e           w_winner;

   assign w_any_req = bus.if_req | bus.dm_req;

   // r_id doubles as the round-robin pointer; its reset value favours dm.
   mem_arb_pick u_pick (
      .if_req  (bus.if_req),
      .dm_req  (bus.dm_req),
      .last_id (r_id),
      .winner  (w_winner)
   );

   // Arbitration FSM: latch the winner, hold the memory for MEM_LAT cycles, ack once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_id        <= REQ_IF;
         r_busy      <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_state  <= ACCESS;
                  r_busy   <= 1'b1;
                  r_cnt    <= CNT_LOAD;
                  r_id     <= w_winner;
                  r_mem_en <= 1'b1;
                  if (w_winner == REQ_DM) begin
                     r_mem_addr  <= bus.dm_addr;
                     r_mem_rw    <= bus.dm_we;
                     r_mem_wdata <= bus.dm_wdata;
                  end else begin
                     r_mem_addr  <= bus.if_addr;
                     r_mem_rw    <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (r_cnt == '0) begin
                  r_state  <= DONE;
                  r_mem_en <= 1'b0;
                  r_mem_rw <= 1'b0;
                  if (r_id == REQ_DM) begin
                     r_dm_ack <= 1'b1;
                     if (!r_mem_rw) begin
                        r_dm_rdata <= bus.mem_rdata;
                     end
                  end else begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= bus.mem_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               r_busy   <= 1'b0;
               r_mem_en <= 1'b0;
               r_mem_rw <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_rw    = r_mem_rw;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.if_ack    = r_if_ack;
   assign bus.dm_ack    = r_dm_ack;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a transaction scoreboard.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MEM_LAT = 2;

   typedef struct {
      req_id_e     id;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   int   en_run = 0;
   exp_t sb[$];

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return {a[15:0], 16'hC0DE};
   endfunction

   // Memory model: data valid whenever the port is enabled.
   assign bus.mem_rdata = bus.mem_en ? mem_f(bus.mem_addr) : 32'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input req_id_e id, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd);
      exp_t e;
      e.id = id; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
      sb.push_back(e);
   endtask

   task automatic wait_ack(output int t);
      bit found = 1'b0;
      t = -1;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (bus.if_ack || bus.dm_ack) begin
            found = 1'b1;
            t = cyc;
         end
      end
      chk("ack_wait", 32'(found), 32'd1);
   endtask

   // Scoreboard monitor: memory-side drive and ack/rdata against the expected head.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         en_run = 0;
      end else begin
         if (bus.mem_en) begin
            en_run++;
            chk("sb_en_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb[0];
               chk("sb_mem_addr", bus.mem_addr, e.addr);
               chk("sb_mem_rw", 32'(bus.mem_rw), 32'(e.we));
               if (e.we) chk("sb_mem_wdata", bus.mem_wdata, e.wdata);
            end
         end
         if (bus.if_ack || bus.dm_ack) begin
            chk("sb_ack_excl", 32'(bus.if_ack & bus.dm_ack), 32'd0);
            chk("sb_ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("sb_ack_id", 32'(bus.dm_ack), 32'(e.id == REQ_DM));
               chk("sb_en_len", 32'(en_run), 32'(MEM_LAT));
               chk("sb_rdata", bus.dm_ack ? bus.dm_rdata : bus.if_rdata, e.rdata);
            end
            en_run = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int ta[4];
      int n_exp;
      int acks;

      rst_n = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
      chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
      chk("rst_dm_ack", 32'(bus.dm_ack), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_if_rdata", bus.if_rdata, 32'h0);
      chk("rst_dm_rdata", bus.dm_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Instruction fetch read at 0x10, cycle by cycle
      bus.if_addr = 32'h10; bus.if_req = 1'b1;
      push(REQ_IF, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_en_c1", 32'(bus.mem_en), 32'd1);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      chk("t1_addr", bus.mem_addr, 32'h10);
      chk("t1_rw", 32'(bus.mem_rw), 32'd0);
      chk("t1_ack_early_c1", 32'(bus.if_ack), 32'd0);
      @(negedge clk);
      chk("t1_en_c2", 32'(bus.mem_en), 32'd1);
      chk("t1_ack_early_c2", 32'(bus.if_ack), 32'd0);
      @(negedge clk);
      chk("t1_ack", 32'(bus.if_ack), 32'd1);
      chk("t1_en_off", 32'(bus.mem_en), 32'd0);
      chk("t1_dm_ack", 32'(bus.dm_ack), 32'd0);
      chk("t1_rdata", bus.if_rdata, 32'hDEADBEEF);
      bus.if_req = 1'b0;
      @(negedge clk);
      chk("t1_ack_pulse", 32'(bus.if_ack), 32'd0);
      chk("t1_busy_idle", 32'(bus.busy), 32'd0);
      @(negedge clk);

      // Data read to give dm_rdata a known non-zero value
      bus.dm_we = 1'b0; bus.dm_addr = 32'h30; bus.dm_req = 1'b1;
      push(REQ_DM, 1'b0, 32'h30, 32'h0, mem_f(32'h30));
      wait_ack(t);
      bus.dm_req = 1'b0;
      chk("t2_rd_data", bus.dm_rdata, mem_f(32'h30));
      repeat (2) @(negedge clk);

      // Data write: dm_rdata must keep the previous read value
      bus.dm_we = 1'b1; bus.dm_addr = 32'h20; bus.dm_wdata = 32'h12345678; bus.dm_req = 1'b1;
      push(REQ_DM, 1'b1, 32'h20, 32'h12345678, mem_f(32'h30));
      @(negedge clk);
      chk("t2_rw_c1", 32'(bus.mem_rw), 32'd1);
      chk("t2_wdata", bus.mem_wdata, 32'h12345678);
      @(negedge clk);
      chk("t2_rw_c2", 32'(bus.mem_rw), 32'd1);
      wait_ack(t);
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      chk("t2_dm_ack", 32'(bus.dm_ack), 32'd1);
      chk("t2_if_ack", 32'(bus.if_ack), 32'd0);
      chk("t2_dm_rdata_held", bus.dm_rdata, mem_f(32'h30));
      chk("t2_rw_off", 32'(bus.mem_rw), 32'd0);
      repeat (2) @(negedge clk);

      // Contention: both requesters raise together
      bus.if_addr = 32'h88; bus.dm_addr = 32'h44;
      bus.if_req = 1'b1; bus.dm_req = 1'b1;
`ifdef MEM_ARB_RR_EN
      n_exp = 4;
`else
      n_exp = 2;
`endif
      for (int i = 0; i < n_exp; i++) begin
         if (i % 2 == 0) push(REQ_DM, 1'b0, 32'h44, 32'h0, mem_f(32'h44));
         else            push(REQ_IF, 1'b0, 32'h88, 32'h0, mem_f(32'h88));
      end
      for (int i = 0; i < n_exp; i++) begin
         wait_ack(ta[i]);
         chk("t3_order_dm", 32'(bus.dm_ack), 32'(i % 2 == 0));
`ifndef MEM_ARB_RR_EN
         if (i == 0) bus.dm_req = 1'b0;
`endif
         if (i > 0) chk("t3_gap", 32'(ta[i] - ta[i-1]), 32'(MEM_LAT + 2));
      end
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("t3_sb_drained", 32'(sb.size()), 32'd0);

      // Reset during the second ACCESS cycle
      bus.if_addr = 32'h50; bus.if_req = 1'b1;
      push(REQ_IF, 1'b0, 32'h50, 32'h0, mem_f(32'h50));
      @(negedge clk);
      @(negedge clk);
      chk("t4_en_before", 32'(bus.mem_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t4_en", 32'(bus.mem_en), 32'd0);
      chk("t4_busy", 32'(bus.busy), 32'd0);
      chk("t4_rw", 32'(bus.mem_rw), 32'd0);
      chk("t4_addr", bus.mem_addr, 32'h0);
      chk("t4_if_rdata", bus.if_rdata, 32'h0);
      chk("t4_dm_rdata", bus.dm_rdata, 32'h0);
      sb.delete();
      bus.if_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.if_ack || bus.dm_ack || bus.mem_en) acks++;
      end
      chk("t4_no_activity", 32'(acks), 32'd0);
      chk("t4_if_rdata_after", bus.if_rdata, 32'h0);

      // Requester changes address and drops request mid-access
      bus.dm_we = 1'b0; bus.dm_addr = 32'h20; bus.dm_req = 1'b1;
      push(REQ_DM, 1'b0, 32'h20, 32'h0, mem_f(32'h20));
      @(negedge clk);
      bus.dm_addr = 32'h40; bus.dm_req = 1'b0;
      chk("t5_addr_c1", bus.mem_addr, 32'h20);
      @(negedge clk);
      chk("t5_addr_c2", bus.mem_addr, 32'h20);
      chk("t5_en_c2", 32'(bus.mem_en), 32'd1);
      wait_ack(t);
      chk("t5_dm_ack", 32'(bus.dm_ack), 32'd1);
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.dm_ack || bus.mem_en) acks++;
      end
      chk("t5_single_ack", 32'(acks), 32'd0);
      chk("t5_rdata", bus.dm_rdata, mem_f(32'h20));
      chk("end_sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width of all address ports.
REQ-002 SHALL have parameter DATA_W, 32, width of all data ports.
REQ-003 SHALL have parameter MEM_LAT, 1, cycles the memory needs from mem_en rise to valid mem_rdata (legal range 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports if_req input 1, if_addr input ADDR_W, if_ack output 1, if_rdata output DATA_W: instruction-fetch read requester.
REQ-007 SHALL have ports dm_req input 1, dm_we input 1 (1=write), dm_addr input ADDR_W, dm_wdata input DATA_W, dm_ack output 1, dm_rdata output DATA_W: data requester.
REQ-008 SHALL have ports mem_en output 1, mem_rw output 1 (1=write), mem_addr output ADDR_W, mem_wdata output DATA_W, mem_rdata input DATA_W: shared single-port memory.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement FSM IDLE, ACCESS, DONE; IDLE->ACCESS when any req high at a rising edge; ACCESS->DONE after MEM_LAT cycles in ACCESS; DONE->IDLE unconditionally.
REQ-011 SHALL latch winner id, address, we and wdata on the IDLE->ACCESS edge; later changes of requester inputs do not affect the access in progress.
REQ-012 SHALL drive mem_en=1 and mem_addr/mem_rw/mem_wdata from latched values for exactly MEM_LAT cycles (all of ACCESS); mem_en=0, mem_rw=0 otherwise.
REQ-013 SHALL capture mem_rdata into the winner's rdata register on the ACCESS->DONE edge for reads only; rdata registers hold value otherwise (writes leave dm_rdata unchanged).
REQ-014 SHALL pulse the winner's ack for exactly one cycle (state DONE); ack appears MEM_LAT+1 edges after the sampling edge; the other ack stays 0.
REQ-015 SHALL treat requests as level-held until ack; a requester still high in the cycle after its ack is a new request.
REQ-016 SHALL, without MEM_ARB_RR_EN, grant dm over if when both request at the same sampling edge.
REQ-017 SHALL, if a req deasserts during ACCESS, complete the access and still pulse ack (no abort).
REQ-018 SHALL force mem_rw=0 for if grants regardless of dm_we.
REQ-019 SHALL count ACCESS cycles with a counter of width clog2(MEM_LAT+1); reloaded on every IDLE->ACCESS edge.
REQ-020 SHALL give throughput of one access per MEM_LAT+2 cycles under continuous requests.

Reset
REQ-021 SHALL, on rst_n low, immediately force state IDLE, mem_en=0, mem_rw=0, if_ack=0, dm_ack=0, busy=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, counter=0, round-robin pointer = dm-favoured.
REQ-022 SHALL, on reset mid-ACCESS, abandon the access with no ack issued; first grant possible at the first rising edge with rst_n high.

Configuration
REQ-023 SHALL support macro MEM_ARB_RR_EN: when defined, contention resolves round-robin (requester not granted last wins; first contention after reset goes to dm); when undefined, fixed dm priority per REQ-016 and no pointer flop exists.
REQ-024 SHALL behave identically in both builds when only one requester is active.

Structure
REQ-025 SHALL place state enum (IDLE/ACCESS/DONE), requester-id enum (REQ_IF/REQ_DM) and default width localparams in shared package mem_arb_pkg.
REQ-026 SHALL implement winner selection in sub-module mem_arb_pick (inputs if_req, dm_req, last id; output winner id), combinational, containing the MEM_ARB_RR_EN selection.

Verification
REQ-027 SHALL cover, MEM_LAT=2: if_req, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en high 2 cycles with mem_addr=0x10, mem_rw=0, if_ack one cycle 3 edges after sampling, if_rdata=0xDEADBEEF.
REQ-028 SHALL cover dm write dm_addr=0x20, dm_wdata=0x12345678 -> mem_rw=1, mem_wdata=0x12345678 for 2 cycles, dm_ack pulse, dm_rdata unchanged.
REQ-029 SHALL cover simultaneous if_req and dm_req held: fixed build -> dm first, if second; RR build -> dm, if, dm, if alternating over 4 accesses, each MEM_LAT+2 cycles apart.
REQ-030 SHALL cover rst_n low in 2nd ACCESS cycle -> mem_en=0 and busy=0 same cycle, no ack after release, outputs at reset values.
REQ-031 SHALL cover dm_addr changed 0x20->0x40 and dm_req dropped during ACCESS -> mem_addr stays 0x20, dm_ack still pulses once.
